// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-serial load/store sequencer between the load buffer / ROB and a byte-wide RAM.
// Define DATA_MEM_CTRL_IO_STALL_EN to hold I/O-mapped stores while io_buffer_full is high.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module data_mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       lb2mem_ready,
    input  logic [2:0]                 lb2mem_load_type,
    input  logic [31:0]                lb2mem_addr,
    input  logic [`ROB_SIZE_WIDTH-1:0] lb2mem_dependency,
    input  logic                       rob_store_valid,
    input  logic [1:0]                 rob_store_type,
    input  logic [31:0]                rob_store_addr,
    input  logic [31:0]                rob_store_value,
    input  logic                       need_flush_in,
    input  logic [7:0]                 mem_din,
    input  logic                       io_buffer_full,
    output logic [31:0]                mem_a,
    output logic [7:0]                 mem_dout,
    output logic                       mem_wr,
    output logic                       mem_valid,
    output logic [`ROB_SIZE_WIDTH-1:0] mem_dependency,
    output logic [31:0]                mem_value,
    output logic                       mem_busy,
    output logic                       store_done
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t                     r_state;
    logic [1:0]                 r_cnt;
    logic [2:0]                 r_type;
    logic [31:0]                r_addr;
    logic [31:0]                r_value;
    logic [31:0]                r_ld_data;
    logic [`ROB_SIZE_WIDTH-1:0] r_dep;
    logic                       r_mem_wr;
    logic [31:0]                r_mem_a;
    logic [7:0]                 r_mem_dout;
    logic                       r_mem_valid;
    logic [`ROB_SIZE_WIDTH-1:0] r_mem_dep;
    logic [31:0]                r_mem_value;
    logic                       r_store_done;

    logic                       r_pend_ld;
    logic [2:0]                 r_pld_type;
    logic [31:0]                r_pld_addr;
    logic [`ROB_SIZE_WIDTH-1:0] r_pld_dep;
    logic                       r_pend_st;
    logic [1:0]                 r_pst_type;
    logic [31:0]                r_pst_addr;
    logic [31:0]                r_pst_value;

    logic [1:0]                 w_st_type;
    logic [31:0]                w_st_addr;
    logic [31:0]                w_st_value;
    logic                       w_st_stall;
    logic                       w_st_go;
    logic                       w_ld_start;
    logic [2:0]                 w_ld_type;
    logic [31:0]                w_ld_addr;
    logic [`ROB_SIZE_WIDTH-1:0] w_ld_dep;
    logic [1:0]                 w_last;
    logic [1:0]                 w_cnt_inc;
    logic [31:0]                w_ld_word;
    logic [31:0]                w_ld_ext;

    // A store strobe arriving in IDLE is started directly, bypassing the pending register.
    assign w_st_type  = r_pend_st ? r_pst_type  : rob_store_type;
    assign w_st_addr  = r_pend_st ? r_pst_addr  : rob_store_addr;
    assign w_st_value = r_pend_st ? r_pst_value : rob_store_value;

`ifdef DATA_MEM_CTRL_IO_STALL_EN
    assign w_st_stall = (w_st_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
`else
    assign w_st_stall = io_buffer_full & 1'b0;
`endif

    assign w_st_go    = (r_state == IDLE) && (r_pend_st || rob_store_valid) && !w_st_stall;
    assign w_ld_start = (r_state == IDLE) && !w_st_go && !need_flush_in && (r_pend_ld || lb2mem_ready);
    assign w_ld_type  = r_pend_ld ? r_pld_type : lb2mem_load_type;
    assign w_ld_addr  = r_pend_ld ? r_pld_addr : lb2mem_addr;
    assign w_ld_dep   = r_pend_ld ? r_pld_dep  : lb2mem_dependency;

    assign w_last    = (r_type[1:0] == 2'b00) ? 2'd0 : (r_type[1:0] == 2'b01) ? 2'd1 : 2'd3;
    assign w_cnt_inc = r_cnt + 2'd1;

    always_comb begin
        w_ld_word = r_ld_data;
        w_ld_word[{r_cnt, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        case (r_type)
            3'b000:  w_ld_ext = {{24{w_ld_word[7]}}, w_ld_word[7:0]};
            3'b001:  w_ld_ext = {{16{w_ld_word[15]}}, w_ld_word[15:0]};
            3'b100:  w_ld_ext = {24'd0, w_ld_word[7:0]};
            3'b101:  w_ld_ext = {16'd0, w_ld_word[15:0]};
            default: w_ld_ext = w_ld_word;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_type       <= 3'd0;
            r_addr       <= 32'd0;
            r_value      <= 32'd0;
            r_ld_data    <= 32'd0;
            r_dep        <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_a      <= 32'd0;
            r_mem_dout   <= 8'd0;
            r_mem_valid  <= 1'b0;
            r_mem_dep    <= '0;
            r_mem_value  <= 32'd0;
            r_store_done <= 1'b0;
            r_pend_ld    <= 1'b0;
            r_pld_type   <= 3'd0;
            r_pld_addr   <= 32'd0;
            r_pld_dep    <= '0;
            r_pend_st    <= 1'b0;
            r_pst_type   <= 2'd0;
            r_pst_addr   <= 32'd0;
            r_pst_value  <= 32'd0;
        end else if (rdy_in) begin
            r_mem_valid  <= 1'b0;
            r_store_done <= 1'b0;

            if (w_st_go) begin
                r_pend_st <= 1'b0;
            end else if (rob_store_valid) begin
                r_pend_st   <= 1'b1;
                r_pst_type  <= rob_store_type;
                r_pst_addr  <= rob_store_addr;
                r_pst_value <= rob_store_value;
            end

            // A new load that cannot start now (or arrives while the pending one starts) is parked.
            if (need_flush_in) begin
                r_pend_ld <= 1'b0;
            end else if (lb2mem_ready && !(w_ld_start && !r_pend_ld)) begin
                r_pend_ld  <= 1'b1;
                r_pld_type <= lb2mem_load_type;
                r_pld_addr <= lb2mem_addr;
                r_pld_dep  <= lb2mem_dependency;
            end else if (w_ld_start) begin
                r_pend_ld <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_st_go) begin
                        r_state    <= STORE;
                        r_type     <= {1'b0, w_st_type};
                        r_addr     <= w_st_addr;
                        r_value    <= w_st_value;
                        r_cnt      <= 2'd0;
                        r_mem_wr   <= 1'b1;
                        r_mem_a    <= w_st_addr;
                        r_mem_dout <= w_st_value[7:0];
                    end else if (w_ld_start) begin
                        r_state   <= LOAD;
                        r_type    <= w_ld_type;
                        r_addr    <= w_ld_addr;
                        r_dep     <= w_ld_dep;
                        r_cnt     <= 2'd0;
                        r_ld_data <= 32'd0;
                        r_mem_a   <= w_ld_addr;
                    end
                end
                LOAD: begin
                    if (need_flush_in) begin
                        r_state <= IDLE;
                    end else begin
                        r_ld_data <= w_ld_word;
                        if (r_cnt == w_last) begin
                            r_state     <= IDLE;
                            r_mem_valid <= 1'b1;
                            r_mem_value <= w_ld_ext;
                            r_mem_dep   <= r_dep;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_mem_a <= r_addr + {30'd0, w_cnt_inc};
                        end
                    end
                end
                STORE: begin
                    if (r_cnt == w_last) begin
                        r_state      <= IDLE;
                        r_mem_wr     <= 1'b0;
                        r_store_done <= 1'b1;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        r_mem_a    <= r_addr + {30'd0, w_cnt_inc};
                        r_mem_dout <= r_value[{w_cnt_inc, 3'b000} +: 8];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_a          = r_mem_a;
    assign mem_dout       = r_mem_dout;
    assign mem_wr         = r_mem_wr & rdy_in;
    assign mem_valid      = r_mem_valid;
    assign mem_dependency = r_mem_dep;
    assign mem_value      = r_mem_value;
    assign store_done     = r_store_done;
    assign mem_busy       = (r_state != IDLE) || r_pend_ld || lb2mem_ready;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a combinational-read byte RAM model.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module tb_data_mem_ctrl;
    localparam int DW = `ROB_SIZE_WIDTH;
    typedef logic [DW-1:0] dep_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic        lb2mem_ready = 1'b0;
    logic [2:0]  lb2mem_load_type = 3'd0;
    logic [31:0] lb2mem_addr = 32'd0;
    dep_t        lb2mem_dependency = '0;
    logic        rob_store_valid = 1'b0;
    logic [1:0]  rob_store_type = 2'd0;
    logic [31:0] rob_store_addr = 32'd0;
    logic [31:0] rob_store_value = 32'd0;
    logic        need_flush_in = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full = 1'b0;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        mem_valid;
    dep_t        mem_dependency;
    logic [31:0] mem_value;
    logic        mem_busy;
    logic        store_done;

    logic        pre_we = 1'b0;
    logic [11:0] pre_a = 12'd0;
    logic [7:0]  pre_d = 8'd0;
    logic [7:0]  ram [0:4095];
    int          wr_count = 0;
    int          checks = 0;
    int          failures = 0;

    data_mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .lb2mem_ready(lb2mem_ready), .lb2mem_load_type(lb2mem_load_type),
        .lb2mem_addr(lb2mem_addr), .lb2mem_dependency(lb2mem_dependency),
        .rob_store_valid(rob_store_valid), .rob_store_type(rob_store_type),
        .rob_store_addr(rob_store_addr), .rob_store_value(rob_store_value),
        .need_flush_in(need_flush_in), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_valid(mem_valid),
        .mem_dependency(mem_dependency), .mem_value(mem_value),
        .mem_busy(mem_busy), .store_done(store_done)
    );

    always #5 clk_in = ~clk_in;

    assign mem_din = ram[mem_a[11:0]];

    always @(posedge clk_in) begin
        if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wr_count <= wr_count + 1;
        end else if (pre_we) begin
            ram[pre_a] <= pre_d;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic issue_load(input logic [2:0] t, input logic [31:0] a, input int d);
        lb2mem_ready = 1'b1; lb2mem_load_type = t; lb2mem_addr = a; lb2mem_dependency = dep_t'(d);
        tick();
        lb2mem_ready = 1'b0;
    endtask

    task automatic issue_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] v);
        rob_store_valid = 1'b1; rob_store_type = t; rob_store_addr = a; rob_store_value = v;
        tick();
        rob_store_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (mem_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int base;
        int vcount;

        preload(12'h100, 8'h80);
        preload(12'h200, 8'h11);
        preload(12'h201, 8'h22);
        preload(12'h202, 8'h33);
        preload(12'h203, 8'h44);
        preload(12'h300, 8'h00);
        preload(12'h301, 8'h00);
        preload(12'h400, 8'h00);
        preload(12'h000, 8'h00);
        preload(12'h500, 8'h00);
        preload(12'h501, 8'h00);

        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_value", mem_value, 32'd0);
        chk("rst_store_done", 32'(store_done), 32'd0);
        chk("rst_mem_busy", 32'(mem_busy), 32'd0);
        $display("txn reset checked");
        rst_in = 1'b0;
        rdy_in = 1'b1;
        tick();

        // LB sign-extends 0x80
        issue_load(3'b000, 32'h100, 3);
        chk("lb_mem_a", mem_a, 32'h100);
        chk("lb_busy", 32'(mem_busy), 32'd1);
        wait_valid(8, lat);
        chk("lb_latency", 32'(lat), 32'd1);
        chk("lb_value", mem_value, 32'hFFFF_FF80);
        chk("lb_dep", 32'(mem_dependency), 32'd3);
        tick();
        chk("lb_valid_pulse", 32'(mem_valid), 32'd0);
        chk("lb_idle_busy", 32'(mem_busy), 32'd0);
        $display("txn LB addr=0x100 value=0x%08h", mem_value);

        issue_load(3'b100, 32'h100, 5);
        wait_valid(8, lat);
        chk("lbu_latency", 32'(lat), 32'd1);
        chk("lbu_value", mem_value, 32'h0000_0080);
        chk("lbu_dep", 32'(mem_dependency), 32'd5);
        $display("txn LBU addr=0x100 value=0x%08h", mem_value);
        tick();

        issue_load(3'b010, 32'h200, 9);
        wait_valid(8, lat);
        chk("lw_latency", 32'(lat), 32'd4);
        chk("lw_value", mem_value, 32'h4433_2211);
        chk("lw_dep", 32'(mem_dependency), 32'd9);
        $display("txn LW addr=0x200 value=0x%08h", mem_value);
        tick();

        // SH and LW arrive together: store first, then the parked load
        base = wr_count;
        rob_store_valid = 1'b1; rob_store_type = 2'b01; rob_store_addr = 32'h300; rob_store_value = 32'h0000_ABCD;
        lb2mem_ready = 1'b1; lb2mem_load_type = 3'b010; lb2mem_addr = 32'h200; lb2mem_dependency = dep_t'(7);
        #1;
        chk("sh_lw_busy_strobe", 32'(mem_busy), 32'd1);
        tick();
        rob_store_valid = 1'b0; lb2mem_ready = 1'b0;
        chk("sh_b0_wr", 32'(mem_wr), 32'd1);
        chk("sh_b0_a", mem_a, 32'h300);
        chk("sh_b0_dout", 32'(mem_dout), 32'hCD);
        chk("sh_b0_busy", 32'(mem_busy), 32'd1);
        tick();
        chk("sh_ram300", 32'(ram[12'h300]), 32'hCD);
        chk("sh_b1_a", mem_a, 32'h301);
        chk("sh_b1_dout", 32'(mem_dout), 32'hAB);
        chk("sh_b1_busy", 32'(mem_busy), 32'd1);
        tick();
        chk("sh_ram301", 32'(ram[12'h301]), 32'hAB);
        chk("sh_done_wr", 32'(mem_wr), 32'd0);
        chk("sh_store_done", 32'(store_done), 32'd1);
        chk("sh_done_busy", 32'(mem_busy), 32'd1);
        tick();
        chk("sh_done_pulse", 32'(store_done), 32'd0);
        chk("sh_ld_start_a", mem_a, 32'h200);
        chk("sh_ld_busy", 32'(mem_busy), 32'd1);
        wait_valid(8, lat);
        chk("sh_ld_latency", 32'(lat), 32'd4);
        chk("sh_ld_value", mem_value, 32'h4433_2211);
        chk("sh_ld_dep", 32'(mem_dependency), 32'd7);
        chk("sh_ld_busy_end", 32'(mem_busy), 32'd0);
        chk("sh_write_count", 32'(wr_count - base), 32'd2);
        $display("txn SH 0xABCD@0x300 then LW value=0x%08h", mem_value);
        tick();

        // flush during byte 1 of an LW, with a same-cycle load request that must be dropped
        issue_load(3'b010, 32'h200, 2);
        tick();
        chk("fl_byte1_a", mem_a, 32'h201);
        need_flush_in = 1'b1;
        lb2mem_ready = 1'b1; lb2mem_load_type = 3'b000; lb2mem_addr = 32'h100; lb2mem_dependency = dep_t'(6);
        tick();
        need_flush_in = 1'b0; lb2mem_ready = 1'b0;
        #1;
        chk("fl_valid", 32'(mem_valid), 32'd0);
        chk("fl_busy", 32'(mem_busy), 32'd0);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_valid) vcount++;
        end
        chk("fl_no_result", 32'(vcount), 32'd0);
        $display("txn LW flushed in byte 1");

        // rdy_in low freezes the store and masks mem_wr
        issue_store(2'b00, 32'h400, 32'h0000_005A);
        chk("rdy_wr_on", 32'(mem_wr), 32'd1);
        rdy_in = 1'b0;
        #1;
        chk("rdy_wr_gated", 32'(mem_wr), 32'd0);
        tick();
        tick();
        chk("rdy_ram_hold", 32'(ram[12'h400]), 32'h00);
        chk("rdy_done_hold", 32'(store_done), 32'd0);
        chk("rdy_a_hold", mem_a, 32'h400);
        rdy_in = 1'b1;
        #1;
        chk("rdy_wr_back", 32'(mem_wr), 32'd1);
        tick();
        chk("rdy_ram_written", 32'(ram[12'h400]), 32'h5A);
        chk("rdy_store_done", 32'(store_done), 32'd1);
        $display("txn SB 0x5A@0x400 across rdy stall");
        tick();

`ifdef DATA_MEM_CTRL_IO_STALL_EN
        io_buffer_full = 1'b1;
        issue_store(2'b00, 32'h0003_0000, 32'h0000_0077);
        chk("io_stall_c0", 32'(mem_wr), 32'd0);
        issue_load(3'b000, 32'h100, 1);
        chk("io_stall_c1", 32'(mem_wr), 32'd0);
        tick();
        chk("io_stall_c2", 32'(mem_wr), 32'd0);
        chk("io_ld_valid", 32'(mem_valid), 32'd1);
        chk("io_ld_value", mem_value, 32'hFFFF_FF80);
        tick();
        chk("io_stall_c3", 32'(mem_wr), 32'd0);
        tick();
        chk("io_stall_c4", 32'(mem_wr), 32'd0);
        io_buffer_full = 1'b0;
        tick();
        chk("io_go_wr", 32'(mem_wr), 32'd1);
        chk("io_go_a", mem_a, 32'h0003_0000);
        tick();
        chk("io_ram", 32'(ram[12'h000]), 32'h77);
        chk("io_done", 32'(store_done), 32'd1);
        $display("txn SB 0x77@0x30000 held by io_buffer_full");
`else
        io_buffer_full = 1'b1;
        issue_store(2'b00, 32'h0003_0000, 32'h0000_0077);
        chk("io_nostall_wr", 32'(mem_wr), 32'd1);
        chk("io_nostall_a", mem_a, 32'h0003_0000);
        tick();
        chk("io_nostall_ram", 32'(ram[12'h000]), 32'h77);
        chk("io_nostall_done", 32'(store_done), 32'd1);
        io_buffer_full = 1'b0;
        $display("txn SB 0x77@0x30000 with io_buffer_full ignored");
`endif
        tick();

        // asynchronous reset in the middle of a SW
        issue_store(2'b10, 32'h500, 32'hDEAD_BEEF);
        chk("sw_b0_dout", 32'(mem_dout), 32'hEF);
        tick();
        chk("sw_ram500", 32'(ram[12'h500]), 32'hEF);
        chk("sw_b1_wr", 32'(mem_wr), 32'd1);
        chk("sw_b1_dout", 32'(mem_dout), 32'hBE);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_mem_wr", 32'(mem_wr), 32'd0);
        chk("arst_mem_a", mem_a, 32'd0);
        chk("arst_mem_dout", 32'(mem_dout), 32'd0);
        chk("arst_mem_valid", 32'(mem_valid), 32'd0);
        chk("arst_mem_value", mem_value, 32'd0);
        chk("arst_mem_dep", 32'(mem_dependency), 32'd0);
        chk("arst_store_done", 32'(store_done), 32'd0);
        chk("arst_mem_busy", 32'(mem_busy), 32'd0);
        tick();
        chk("arst_ram501", 32'(ram[12'h501]), 32'h00);
        rst_in = 1'b0;
        tick();
        chk("arst_after_wr", 32'(mem_wr), 32'd0);
        $display("txn SW 0xDEADBEEF@0x500 aborted by reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter IO_ADDR_HI, default 2'b11: addr[17:16] value that marks an I/O address.
REQ-002 SHALL have clk_in  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have rst_in  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have rdy_in  input  1  low = freeze all state.
REQ-005 SHALL have lb2mem_ready  input  1  load request strobe, one cycle per request.
REQ-006 SHALL have lb2mem_load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 SHALL have lb2mem_addr  input  32  load byte address; lb2mem_dependency  input  `ROB_SIZE_WIDTH  load ROB id.
REQ-008 SHALL have rob_store_valid  input  1  committed-store strobe; rob_store_type  input  2  00 byte, 01 half, 10 word.
REQ-009 SHALL have rob_store_addr  input  32 and rob_store_value  input  32: store address and data.
REQ-010 SHALL have need_flush_in  input  1  mispredict flush.
REQ-011 SHALL have mem_din  input  8  RAM read byte; io_buffer_full  input  1  I/O write FIFO full.
REQ-012 SHALL have mem_a  output  32, mem_dout  output  8, mem_wr  output  1 (1 = write): RAM port.
REQ-013 SHALL have mem_valid  output  1, mem_dependency  output  `ROB_SIZE_WIDTH, mem_value  output  32: load result broadcast.
REQ-014 SHALL have mem_busy  output  1 (combinational) and store_done  output  1 (one-cycle pulse to ROB).

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, STORE with a 2-bit byte counter cnt; byte count n = 1/2/4 from the type.
REQ-016 SHALL assert mem_busy = (state!=IDLE) | pend_ld | lb2mem_ready.
REQ-017 SHALL accept every lb2mem_ready pulse: start it if IDLE and no store is startable, otherwise latch it in a one-entry pending-load register (pend_ld).
REQ-018 SHALL accept every rob_store_valid pulse into a one-entry pending-store register (pend_st); ROB sends no further store before store_done.
REQ-019 SHALL, in IDLE, start the pending store before any load (store wins a simultaneous arrival); a same-cycle strobe is started directly without first being registered.
REQ-020 SHALL for LOAD: on the start edge drive mem_a=addr, cnt=0; on each later edge capture mem_din as byte cnt (little-endian); if cnt==n-1 go to IDLE, else mem_a=addr+cnt+1 and cnt+1.
REQ-021 SHALL pulse mem_valid for exactly one cycle after the last byte with mem_dependency = ROB id; LB/LH sign-extend, LBU/LHU zero-extend, LW passes 32 bits; load latency = n edges after start.
REQ-022 SHALL for STORE: on the start edge drive mem_wr=1, mem_a=addr, mem_dout=value[7:0]; on following edges drive byte k at addr+k; after byte n-1, mem_wr=0, store_done pulses one cycle, go to IDLE (latency n edges).
REQ-023 SHALL compute address arithmetic modulo 2^32 with no alignment check.
REQ-024 SHALL on need_flush_in: abort an in-progress LOAD (no mem_valid), clear pend_ld, and ignore a same-cycle lb2mem_ready; an in-progress or pending store is unaffected; flush has priority over a same-cycle load result.
REQ-025 SHALL hold all registers when rdy_in=0 and gate mem_wr with rdy_in.

Reset
REQ-026 SHALL on rst_in: state=IDLE, cnt=0, pend_ld=pend_st=0, mem_wr=0, mem_a=0, mem_dout=0, mem_valid=0, store_done=0, mem_value=0, mem_dependency=0, immediately and regardless of clock or rdy_in; an in-progress transfer is dropped.

Configuration
REQ-027 SHALL, with DATA_MEM_CTRL_IO_STALL_EN defined, keep a store to an I/O address (addr[17:16]==IO_ADDR_HI) pending while io_buffer_full=1 and let loads proceed meanwhile; without the macro, io_buffer_full SHALL be ignored.

Verification
REQ-028 SHALL verify: LB at 0x100 with RAM[0x100]=0x80 -> mem_valid 1 edge after start, value 0xFFFFFF80; LBU -> 0x00000080.
REQ-029 SHALL verify: LW at 0x200 with bytes 11,22,33,44 -> mem_valid 4 edges after start, value 0x44332211, correct ROB id.
REQ-030 SHALL verify: SH 0xABCD to 0x300 arriving together with an LW -> writes CD@0x300 then AB@0x301, store_done, then the load starts with mem_busy high throughout.
REQ-031 SHALL verify: need_flush_in in the 2nd byte of an LW -> no mem_valid, FSM IDLE next edge, mem_busy low.
REQ-032 SHALL verify: with macro defined, SB to 0x30000 while io_buffer_full=1 for 5 cycles -> mem_wr stays low for those 5 cycles, write occurs the edge after full drops.
REQ-033 SHALL verify: rst_in asserted mid-SW -> mem_wr falls asynchronously and all outputs hold reset values.
